cnn_kernel_ctrl: RTL and testbench

Sequencer and channel accumulator for one `cnn_kernel` instance.
- On a run command it issues one kernel beat per cycle: for each output pixel, one beat per input channel, in pixel-major / channel-minor order.
- It exports the pixel and channel indices so upstream buffers can mux the window and weights.
- It sums the returned per-channel kernel results into one value per output pixel and presents it on a valid/ready output port.
- It sits between the layer controller and the kernel datapath inside `cnn_core`.

---
 rtl/cnn_kernel_ctrl.sv | 106 ++++++++++
 tb/tb_cnn_kernel_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_kernel_ctrl.sv
// cnn_kernel_ctrl: issues kernel beats pixel-major/channel-minor and sums returned channel results per pixel
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   i_run, i_num_pix                start pulse and output pixel count (latched when accepted in IDLE)
//   o_idle, o_done, o_soft_reset    idle level, end-of-run pulse, kernel pipeline clear pulse
//   o_k_valid, o_k_ich, o_k_pix     kernel beat issue with its channel and pixel index
//   i_k_valid, i_k_acc              returned per-channel kernel result (signed)
//   o_valid, o_data, o_pix, i_ready channel-sum output stream (signed data) with downstream accept
module cnn_kernel_ctrl #(
   parameter int ICH    = 4,
   parameter int CH_BW  = 2,
   parameter int PIX_BW = 16,
   parameter int AK_BW  = 20,
   parameter int ACI_BW = 22
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_run,
   input  logic [PIX_BW-1:0]        i_num_pix,
   output logic                     o_idle,
   output logic                     o_done,
   output logic                     o_soft_reset,
   output logic                     o_k_valid,
   output logic [CH_BW-1:0]         o_k_ich,
   output logic [PIX_BW-1:0]        o_k_pix,
   input  logic                     i_k_valid,
   input  logic signed [AK_BW-1:0]  i_k_acc,
   output logic                     o_valid,
   output logic signed [ACI_BW-1:0] o_data,
   output logic [PIX_BW-1:0]        o_pix,
   input  logic                     i_ready
);
   typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} state_t;
   localparam logic [CH_BW-1:0] LAST_ICH = CH_BW'(ICH - 1);
   state_t state, state_nx;
   logic [PIX_BW-1:0] num_pix, ret_pix;
   logic [CH_BW-1:0] ret_ich;
   logic signed [ACI_BW-1:0] acc, sum;
   logic final_pending, k_final, stall, issue_final, ret, ret_final, load;
   // A pixel's final beat waits until the previous sum has left the output
   // register path, so a new load can never overwrite an unaccepted result.
   assign k_final = o_k_ich == LAST_ICH;
   assign stall = k_final && (final_pending || (o_valid && !i_ready));
   assign issue_final = o_k_valid && k_final;
   assign ret = i_k_valid && (state == RUN || state == DRAIN);
   assign ret_final = ret_ich == LAST_ICH;
   assign load = ret && ret_final;
   assign sum = (ret_ich == '0 ? '0 : acc) + ACI_BW'(i_k_acc);
   always_comb begin
      state_nx = state;
      o_idle = state == IDLE;
      o_done = state == DONE;
      o_soft_reset = state == CLR;
      o_k_valid = state == RUN && !stall;
      case (state)
         IDLE:    state_nx = i_run ? CLR : IDLE;
         CLR:     state_nx = num_pix == '0 ? DONE : RUN;
         RUN:     state_nx = issue_final && o_k_pix == num_pix - 1'b1 ? DRAIN : RUN;
         DRAIN:   state_nx = ret_pix == num_pix && !o_valid ? DONE : DRAIN;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         num_pix <= '0;
         o_k_ich <= '0;
         o_k_pix <= '0;
         ret_ich <= '0;
         ret_pix <= '0;
         acc <= '0;
         final_pending <= 1'b0;
         o_valid <= 1'b0;
         o_data <= '0;
         o_pix <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && i_run) num_pix <= i_num_pix;
         if (state == CLR) begin
            o_k_ich <= '0;
            o_k_pix <= '0;
            ret_ich <= '0;
            ret_pix <= '0;
            acc <= '0;
            final_pending <= 1'b0;
         end else begin
            if (o_k_valid) begin
               o_k_ich <= k_final ? '0 : o_k_ich + 1'b1;
               if (k_final) o_k_pix <= o_k_pix + 1'b1;
            end
            if (ret) begin
               acc <= sum;
               ret_ich <= ret_final ? '0 : ret_ich + 1'b1;
               if (ret_final) ret_pix <= ret_pix + 1'b1;
            end
            if (issue_final) final_pending <= 1'b1;
            else if (load) final_pending <= 1'b0;
         end
         if (load) begin
            o_data <= sum;
            o_pix <= ret_pix;
         end
         o_valid <= load || (o_valid && !i_ready);
      end
   end
endmodule

// File: tb/tb_cnn_kernel_ctrl.sv
// tb_cnn_kernel_ctrl: directed bench with a beat/sum scoreboard for cnn_kernel_ctrl (ICH=4 and ICH=1 instances)
module tb_cnn_kernel_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic run_a = 0, idle_a, done_a, srst_a, kv_a, rkv_a = 0, ov_a, rdy_a = 1;
   logic [15:0] num_a = 0, kpix_a, op_a;
   logic [1:0] kich_a;
   logic signed [19:0] racc_a = 0;
   logic signed [21:0] od_a;

   logic run_b = 0, idle_b, done_b, srst_b, kv_b, rkv_b = 0, ov_b, rdy_b = 1;
   logic [15:0] num_b = 0, kpix_b, op_b;
   logic [0:0] kich_b;
   logic signed [19:0] racc_b = 0;
   logic signed [19:0] od_b;

   cnn_kernel_ctrl #(.ICH(4), .CH_BW(2), .PIX_BW(16), .AK_BW(20), .ACI_BW(22)) dut_a (
      .clk(clk), .reset_n(reset_n), .i_run(run_a), .i_num_pix(num_a),
      .o_idle(idle_a), .o_done(done_a), .o_soft_reset(srst_a),
      .o_k_valid(kv_a), .o_k_ich(kich_a), .o_k_pix(kpix_a),
      .i_k_valid(rkv_a), .i_k_acc(racc_a),
      .o_valid(ov_a), .o_data(od_a), .o_pix(op_a), .i_ready(rdy_a));

   cnn_kernel_ctrl #(.ICH(1), .CH_BW(1), .PIX_BW(16), .AK_BW(20), .ACI_BW(20)) dut_b (
      .clk(clk), .reset_n(reset_n), .i_run(run_b), .i_num_pix(num_b),
      .o_idle(idle_b), .o_done(done_b), .o_soft_reset(srst_b),
      .o_k_valid(kv_b), .o_k_ich(kich_b), .o_k_pix(kpix_b),
      .i_k_valid(rkv_b), .i_k_acc(racc_b),
      .o_valid(ov_b), .o_data(od_b), .o_pix(op_b), .i_ready(rdy_b));

   int compared = 0, mismatched = 0;
   int cyc = 0;
   int kv[4];
   int koff = 0;
   int sv_a[8], sd_a[8], sv_b[8], sd_b[8];
   int eb_pix[64], eb_ich[64], eo_pix[16], eo_dat[16];
   int exp_nb, exp_no, bp, op;
   int t_a = 0, lo_s = 0, lo_n = 0;
   int soft_cyc, beat_first, beat_last, beat_n, hold_n, done_n, done_cyc, on;
   int out_cyc[16], out_pix[16];
   longint out_dat[16];
   logic held = 0;
   longint hd = 0, hp = 0;
   int nbb, nob, done_nb, done_cyc_b;
   int bc_b[16], bpx_b[16], oc_b[16], opx_b[16];
   longint od_rec_b[16];

   task automatic chk(input string nm, input longint act, input longint exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int kval(input int p, input int c);
      return kv[c] + koff * p;
   endfunction

   // One clock: drive this cycle's inputs just after the edge, then check and
   // record at the falling edge. The kernel stand-in returns each beat 2 cycles later.
   task automatic tick();
      int p;
      @(posedge clk);
      cyc++;
      #1;
      rdy_a = !(cyc >= t_a + lo_s && cyc < t_a + lo_s + lo_n);
      rkv_a = sv_a[cyc % 8] != 0;
      racc_a = 20'(sd_a[cyc % 8]);
      sv_a[cyc % 8] = 0;
      rkv_b = sv_b[cyc % 8] != 0;
      racc_b = 20'(sd_b[cyc % 8]);
      sv_b[cyc % 8] = 0;
      @(negedge clk);
      if (idle_a) chk("idle_quiet", {kv_a, ov_a, done_a, srst_a}, 0);
      if (srst_a) begin
         soft_cyc = cyc;
         foreach (sv_a[i]) sv_a[i] = 0;
      end
      if (kv_a) begin
         if (bp >= exp_nb) begin
            compared++;
            mismatched++;
            $display("FAIL beat_extra: beat %0d issued (pix %0d ich %0d), only %0d planned", bp, kpix_a, kich_a, exp_nb);
         end else begin
            chk("beat_pix", kpix_a, eb_pix[bp]);
            chk("beat_ich", kich_a, eb_ich[bp]);
         end
         bp++;
         if (beat_n == 0) beat_first = cyc;
         beat_last = cyc;
         beat_n++;
         sv_a[(cyc + 2) % 8] = 1;
         sd_a[(cyc + 2) % 8] = kval(int'(kpix_a), int'(kich_a));
      end
      if (ov_a) begin
         if (held) begin
            chk("hold_data", od_a, hd);
            chk("hold_pix", op_a, hp);
         end
         if (rdy_a) begin
            if (op >= exp_no) begin
               compared++;
               mismatched++;
               $display("FAIL out_extra: output %0d (pix %0d data %0d), only %0d planned", op, op_a, od_a, exp_no);
            end else begin
               chk("out_pix", op_a, eo_pix[op]);
               chk("out_data", od_a, eo_dat[op]);
            end
            op++;
            if (on < 16) begin
               out_cyc[on] = cyc;
               out_pix[on] = int'(op_a);
               out_dat[on] = od_a;
            end
            on++;
         end else hold_n++;
      end
      held = ov_a && !rdy_a;
      hd = od_a;
      hp = op_a;
      if (done_a) begin
         done_n++;
         done_cyc = cyc;
      end
      if (srst_b) foreach (sv_b[i]) sv_b[i] = 0;
      if (kv_b) begin
         p = int'(kpix_b);
         if (nbb < 16) begin
            bc_b[nbb] = cyc;
            bpx_b[nbb] = p;
         end
         nbb++;
         sv_b[(cyc + 2) % 8] = 1;
         sd_b[(cyc + 2) % 8] = 7 * (p + 1) - 20;
      end
      if (ov_b && rdy_b) begin
         if (nob < 16) begin
            oc_b[nob] = cyc;
            opx_b[nob] = int'(op_b);
            od_rec_b[nob] = od_b;
         end
         nob++;
      end
      if (done_b) begin
         done_nb++;
         done_cyc_b = cyc;
      end
   endtask

   // Expected beat order and per-pixel channel sums for a run of np pixels.
   task automatic plan_a(input int np);
      int s;
      exp_nb = 0;
      exp_no = 0;
      for (int p = 0; p < np; p++) begin
         s = 0;
         for (int c = 0; c < 4; c++) begin
            eb_pix[exp_nb] = p;
            eb_ich[exp_nb] = c;
            exp_nb++;
            s += kval(p, c);
         end
         eo_pix[exp_no] = p;
         eo_dat[exp_no] = s;
         exp_no++;
      end
      bp = 0;
      op = 0;
      soft_cyc = -1;
      beat_first = -1;
      beat_last = -1;
      beat_n = 0;
      hold_n = 0;
      done_n = 0;
      done_cyc = -1;
      on = 0;
   endtask

   task automatic start_a(input int np, input int s, input int n);
      plan_a(np);
      lo_s = s;
      lo_n = n;
      num_a = 16'(np);
      run_a = 1;
      t_a = cyc + 2;
      tick();
      run_a = 0;
   endtask

   task automatic finish_a(input int budget);
      int n = 0;
      while (done_n == 0 && n < budget) begin
         tick();
         n++;
      end
      if (done_n == 0) begin
         compared++;
         mismatched++;
         $display("FAIL done_timeout: no o_done within %0d cycles", budget);
      end
      tick();
      chk("back_to_idle", idle_a, 1);
      chk("all_beats", bp, exp_nb);
      chk("all_outs", op, exp_no);
      chk("done_once", done_n, 1);
   endtask

   initial begin
      int t, n;
      kv = '{10, -3, 5, 1};
      plan_a(0);
      repeat (3) tick();
      chk("rst_idle", {idle_a, idle_b}, 2'b11);
      chk("rst_kv", {kv_a, kv_b, done_a, srst_a}, 0);
      chk("rst_out", {ov_a, od_a, op_a, kpix_a, kich_a}, 0);
      reset_n = 1;
      tick();

      // Basic run: 2 pixels, kernel returns 10,-3,5,1 -> 13 per pixel
      start_a(2, 0, 0);
      finish_a(40);
      t = t_a;
      chk("t1_soft_cyc", soft_cyc, t - 1);
      chk("t1_first_beat", beat_first, t);
      chk("t1_last_beat", beat_last, t + 7);
      chk("t1_nbeats", beat_n, 8);
      chk("t1_out0_cyc", out_cyc[0], t + 6);
      chk("t1_out0_data", out_dat[0], 13);
      chk("t1_out1_cyc", out_cyc[1], t + 10);
      chk("t1_out1_pix", out_pix[1], 1);
      chk("t1_out1_data", out_dat[1], 13);
      chk("t1_done_cyc", done_cyc, t + 12);

      // Zero pixels: CLR then straight to DONE
      start_a(0, 0, 0);
      chk("t2_not_idle_clr", idle_a, 0);
      finish_a(10);
      t = t_a;
      chk("t2_soft_cyc", soft_cyc, t - 1);
      chk("t2_done_cyc", done_cyc, t);
      chk("t2_nbeats", beat_n, 0);
      chk("t2_nouts", on, 0);

      // Backpressure: i_ready low for 6 cycles from pixel 0's result
      kv = '{1, 2, 3, 4};
      koff = 100;
      start_a(2, 6, 6);
      finish_a(60);
      t = t_a;
      chk("t3_hold_cycles", hold_n, 6);
      chk("t3_out0_cyc", out_cyc[0], t + 12);
      chk("t3_out0_data", out_dat[0], 10);
      chk("t3_final_beat_cyc", beat_last, t + 12);
      chk("t3_out1_cyc", out_cyc[1], t + 15);
      chk("t3_out1_data", out_dat[1], 410);
      chk("t3_done_cyc", done_cyc, t + 17);

      // ICH=1 instance: one beat every 3 cycles
      num_b = 3;
      run_b = 1;
      t = cyc + 2;
      tick();
      run_b = 0;
      n = 0;
      while (done_nb == 0 && n < 40) begin
         tick();
         n++;
      end
      if (done_nb == 0) begin
         compared++;
         mismatched++;
         $display("FAIL b_done_timeout: no o_done within 40 cycles");
      end
      tick();
      chk("b_nbeats", nbb, 3);
      chk("b_nouts", nob, 3);
      for (int i = 0; i < 3; i++) begin
         chk("b_beat_cyc", bc_b[i], t + 3 * i);
         chk("b_beat_pix", bpx_b[i], i);
         chk("b_out_cyc", oc_b[i], t + 3 + 3 * i);
         chk("b_out_pix", opx_b[i], i);
      end
      chk("b_out0_data", od_rec_b[0], -13);
      chk("b_out1_data", od_rec_b[1], -6);
      chk("b_out2_data", od_rec_b[2], 1);
      chk("b_done", done_nb, 1);
      chk("b_done_cyc", done_cyc_b, t + 11);

      // Most negative kernel result on every channel
      kv = '{-524288, -524288, -524288, -524288};
      koff = 0;
      start_a(1, 0, 0);
      finish_a(40);
      chk("t5_min_sum", out_dat[0], -2097152);

      // Reset mid-run, then restart from pixel 0
      kv = '{10, -3, 5, 1};
      start_a(3, 0, 0);
      while (cyc < t_a + 6) tick();
      chk("t6_pre_valid", ov_a, 1);
      chk("t6_pre_data", od_a, 13);
      reset_n = 0;
      #1;
      chk("t6_rst_idle", idle_a, 1);
      chk("t6_rst_ctl", {kv_a, done_a, srst_a}, 0);
      chk("t6_rst_idx", {kpix_a, kich_a}, 0);
      chk("t6_rst_out", {ov_a, od_a, op_a}, 0);
      repeat (3) tick();
      reset_n = 1;
      tick();
      start_a(1, 0, 0);
      finish_a(40);
      chk("t6_first_beat", beat_first, t_a);
      chk("t6_out_pix", out_pix[0], 0);
      chk("t6_out_data", out_dat[0], 13);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
